// File: rtl/alu_issue_q_if.sv
// alu_issue_q_if: request, ALU-drive and response signals of alu_issue_q.
// The slave modport is the issue queue; the master modport is the
// surrounding logic (decode/issue on the request side, the combinational
// ALU on the alu_* wires, the consumer on the response side).
interface alu_issue_q_if #(
  parameter int TAGW = 2
);
  logic            req_valid;
  logic            req_ready;
  logic [7:0]      req_a;
  logic [7:0]      req_b;
  logic [1:0]      req_op;
  logic [TAGW-1:0] req_tag;

  logic [7:0]      alu_r0_rd;
  logic [7:0]      alu_rs;
  logic [1:0]      alu_control;
  logic [7:0]      alu_result;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    output req_ready, alu_r0_rd, alu_rs, alu_control,
           rsp_valid, rsp_data, rsp_tag, rsp_zero
  );

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, alu_result, rsp_ready,
    input  req_ready, alu_r0_rd, alu_rs, alu_control,
           rsp_valid, rsp_data, rsp_tag, rsp_zero
  );
endinterface

// File: rtl/alu_issue_q.sv
// alu_issue_q: in-order operation queue in front of the 8-bit combinational
// ALU. The head entry drives the ALU; its result is captured into a single
// valid/ready response slot together with the caller tag.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Request side: req_ready depends only on the registered count.
// Response side: rsp_valid stays high and rsp_data/rsp_tag/rsp_zero stay
// stable until rsp_ready is seen; rsp_ready feeds the issue decision
// combinationally so the slot can be refilled in the cycle it is emptied.
//
// Optional feature: define ALU_ISSUE_ZERO_EN to register rsp_zero
// (result == 0); otherwise rsp_zero is tied to 0.
module alu_issue_q #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_issue_q_if.slave bus,
  output logic         o_rsp_state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } rsp_state_t;

  // Queue storage and bookkeeping
  logic [7:0]      r_a   [DEPTH];
  logic [7:0]      r_b   [DEPTH];
  logic [1:0]      r_op  [DEPTH];
  logic [TAGW-1:0] r_tag [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Response slot
  rsp_state_t      r_state;
  rsp_state_t      w_state_nxt;
  logic [7:0]      r_rsp_data;
  logic [TAGW-1:0] r_rsp_tag;

  logic            w_req_ready;
  logic            w_not_empty;
  logic            w_rsp_valid;
  logic            w_push;
  logic            w_issue;
  logic [7:0]      w_head_a;
  logic [7:0]      w_head_b;
  logic [1:0]      w_head_op;
  logic [TAGW-1:0] w_head_tag;

  assign w_req_ready = (r_count != CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_rsp_valid = (r_state == S_FULL);
  assign w_push      = bus.req_valid && w_req_ready;
  assign w_issue     = w_not_empty && (!w_rsp_valid || bus.rsp_ready);

  assign w_head_a    = r_a[r_rd_ptr];
  assign w_head_b    = r_b[r_rd_ptr];
  assign w_head_op   = r_op[r_rd_ptr];
  assign w_head_tag  = r_tag[r_rd_ptr];

  // Storage write; entries are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_a[r_wr_ptr]   <= bus.req_a;
      r_b[r_wr_ptr]   <= bus.req_b;
      r_op[r_wr_ptr]  <= bus.req_op;
      r_tag[r_wr_ptr] <= bus.req_tag;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response slot next state: fill on issue, drain when taken with nothing to refill
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_issue) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_issue) begin
          w_state_nxt = S_FULL;
        end else if (bus.rsp_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Capture the ALU result and tag of the head entry on issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_rsp_tag  <= '0;
    end else if (w_issue) begin
      r_rsp_data <= bus.alu_result;
      r_rsp_tag  <= w_head_tag;
    end
  end

`ifdef ALU_ISSUE_ZERO_EN
  logic r_rsp_zero;

  // Zero flag tracks the captured result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_zero <= 1'b0;
    end else if (w_issue) begin
      r_rsp_zero <= (bus.alu_result == 8'd0);
    end
  end

  assign bus.rsp_zero = r_rsp_zero;
`else
  assign bus.rsp_zero = 1'b0;
`endif

  // ALU operands come from the head entry, forced to zero when nothing is queued
  assign bus.alu_r0_rd   = w_not_empty ? w_head_a  : 8'd0;
  assign bus.alu_rs      = w_not_empty ? w_head_b  : 8'd0;
  assign bus.alu_control = w_not_empty ? w_head_op : 2'd0;

  assign bus.req_ready   = w_req_ready;
  assign bus.rsp_valid   = w_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_tag     = r_rsp_tag;
  assign o_rsp_state     = r_state;

endmodule
